// File: rtl/muldiv_sequencer_pkg.sv
// Shared RV32M op codes and sequencer state encodings for the multiply/divide unit.
package muldiv_sequencer_pkg;

  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_MUL    = 5'd10;
  localparam logic [4:0] ALU_MULH   = 5'd11;
  localparam logic [4:0] ALU_MULHSU = 5'd12;
  localparam logic [4:0] ALU_MULHU  = 5'd13;
  localparam logic [4:0] ALU_DIV    = 5'd14;
  localparam logic [4:0] ALU_DIVU   = 5'd15;
  localparam logic [4:0] ALU_REM    = 5'd16;
  localparam logic [4:0] ALU_REMU   = 5'd17;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_FIN  = 2'd3
  } md_state_e;

  function automatic logic is_mul_op(input logic [4:0] code);
    return code inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
  endfunction

  function automatic logic is_div_op(input logic [4:0] code);
    return code inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_signed_div(input logic [4:0] code);
    return code inside {ALU_DIV, ALU_REM};
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned restoring divider: one quotient bit per clock, `last` pulses once the final bit is in.
module muldiv_div_core #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            kill,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);

  localparam int CNT_W = $clog2(ITERS);

  logic [XLEN-1:0]  quo_p0, rem_p0, dvs_p0;
  logic [CNT_W-1:0] cnt;
  logic             active, last_r;
  logic [XLEN:0]    shifted, diff;
  logic             ge;

  // The quotient register doubles as the dividend shifter.
  assign shifted = {rem_p0, quo_p0[XLEN-1]};
  assign diff    = shifted - {1'b0, dvs_p0};
  assign ge      = ~diff[XLEN];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_p0 <= '0;
      rem_p0 <= '0;
      dvs_p0 <= '0;
      cnt    <= '0;
      active <= 1'b0;
      last_r <= 1'b0;
    end else if (kill) begin
      active <= 1'b0;
      last_r <= 1'b0;
    end else if (load) begin
      quo_p0 <= dividend;
      rem_p0 <= '0;
      dvs_p0 <= divisor;
      cnt    <= '0;
      active <= 1'b1;
      last_r <= 1'b0;
    end else begin
      last_r <= 1'b0;
      if (active) begin
        rem_p0 <= ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_p0 <= {quo_p0[XLEN-2:0], ge};
        cnt    <= cnt + 1'b1;
        if (cnt == CNT_W'(ITERS - 1)) begin
          active <= 1'b0;
          last_r <= 1'b1;
        end
      end
    end
  end

  assign quotient  = quo_p0;
  assign remainder = rem_p0;
  assign last      = last_r;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M execution controller: single-cycle multiply, 32-step divide, one-cycle done pulse.
// Define MULDIV_FASTPATH_EN to finish div-by-zero / signed-overflow cases without iterating.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  md_state_e state, state_n, target;

  logic                   valid_op, accept, fast_in, div_load, div_last;
  logic [4:0]             op_p0;
  logic [XLEN-1:0]        a_p0, b_p0, div_q, div_r, dvd_abs, dvs_abs;
  logic [XLEN-1:0]        mul_res, div_res;
  logic signed [2*XLEN-1:0] mul_a, mul_b, prod, prod_p0;

  // Overrides for x/0 and MIN/-1 take precedence over whatever the iterator produced.
  function automatic logic [XLEN-1:0] div_fix(input logic [4:0] f_op,
                                              input logic [XLEN-1:0] f_a, f_b, f_q, f_r);
    logic            sgn, is_rem;
    logic [XLEN-1:0] qs, rs;
    sgn    = is_signed_div(f_op);
    is_rem = (f_op == ALU_REM) || (f_op == ALU_REMU);
    qs     = (sgn && (f_a[XLEN-1] ^ f_b[XLEN-1])) ? -f_q : f_q;
    rs     = (sgn && f_a[XLEN-1]) ? -f_r : f_r;
    if (f_b == '0)
      return is_rem ? f_a : '1;
    if (sgn && f_a == {1'b1, {(XLEN-1){1'b0}}} && f_b == '1)
      return is_rem ? '0 : f_a;
    return is_rem ? rs : qs;
  endfunction

  assign valid_op = is_mul_op(op) || is_div_op(op);
  assign accept   = start && valid_op && !kill && (state == MD_IDLE || state == MD_FIN);
  assign busy     = (start && valid_op && !kill && state == MD_IDLE)
                  || state == MD_MUL || state == MD_DIV;
  assign done     = (state == MD_FIN);

`ifdef MULDIV_FASTPATH_EN
  logic special_in;
  assign special_in = is_div_op(op) && ((b == '0) ||
                      (is_signed_div(op) && a == {1'b1, {(XLEN-1){1'b0}}} && b == '1));
  assign fast_in    = special_in;
`else
  assign fast_in    = 1'b0;
`endif

  assign target   = (is_mul_op(op) || fast_in) ? MD_MUL : MD_DIV;
  assign div_load = accept && is_div_op(op) && !fast_in;

  assign mul_a   = {{XLEN{a[XLEN-1] && (op == ALU_MULH || op == ALU_MULHSU)}}, a};
  assign mul_b   = {{XLEN{b[XLEN-1] && (op == ALU_MULH)}}, b};
  assign prod    = mul_a * mul_b;
  assign dvd_abs = (is_signed_div(op) && a[XLEN-1]) ? -a : a;
  assign dvs_abs = (is_signed_div(op) && b[XLEN-1]) ? -b : b;

  muldiv_div_core #(
    .XLEN  (XLEN),
    .ITERS (DIV_ITERS)
  ) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .kill      (kill && state == MD_DIV),
    .dividend  (dvd_abs),
    .divisor   (dvs_abs),
    .quotient  (div_q),
    .remainder (div_r),
    .last      (div_last)
  );

  assign mul_res = is_div_op(op_p0) ? div_fix(op_p0, a_p0, b_p0, '0, '0) :
                   (op_p0 == ALU_MUL) ? prod_p0[XLEN-1:0] : prod_p0[2*XLEN-1:XLEN];
  assign div_res = div_fix(op_p0, a_p0, b_p0, div_q, div_r);

  always_comb begin
    state_n = state;
    case (state)
      MD_IDLE: if (accept) state_n = target;
      MD_MUL:  state_n = kill ? MD_IDLE : MD_FIN;
      MD_DIV:  if (kill) state_n = MD_IDLE;
               else if (div_last) state_n = MD_FIN;
      MD_FIN:  state_n = accept ? target : MD_IDLE;
      default: state_n = MD_IDLE;
    endcase
  end

  // Acceptance edge latches operands and the product; result updates on the exit from MUL/DIV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MD_IDLE;
      op_p0   <= '0;
      a_p0    <= '0;
      b_p0    <= '0;
      prod_p0 <= '0;
      result  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op_p0   <= op;
        a_p0    <= a;
        b_p0    <= b;
        prod_p0 <= prod;
      end
      if (state == MD_MUL && !kill)
        result <= mul_res;
      else if (state == MD_DIV && div_last && !kill)
        result <= div_res;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: vector table plus kill/reset/back-to-back sequences.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [4:0]  op = ALU_ADD;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] result;

`ifdef MULDIV_FASTPATH_EN
  localparam int SLAT = 1;
`else
  localparam int SLAT = 33;
`endif

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res_exp;
    int          lat;
  } vec_t;

  vec_t vecs[16];
  int   tests = 0;
  int   fails = 0;

  muldiv_sequencer #(.XLEN(32), .DIV_ITERS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic launch(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  // Passes the acceptance edge, scrambles inputs, then counts busy cycles until done.
  task automatic wait_done(output int lat, output int bc, output logic [31:0] res);
    lat = -1;
    bc  = 0;
    @(posedge clk); #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = ALU_MUL;
    res   = result;
    for (int k = 1; k <= 60; k++) begin
      if (busy) bc++;
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        res = result;
        break;
      end
    end
  endtask

  initial begin
    int          lat, bc, dn;
    logic [31:0] res, saved;

    vecs[0]  = '{ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1};
    vecs[1]  = '{ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1};
    vecs[2]  = '{ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1};
    vecs[3]  = '{ALU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1};
    vecs[4]  = '{ALU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
    vecs[5]  = '{ALU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
    vecs[6]  = '{ALU_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, SLAT};
    vecs[7]  = '{ALU_REMU,   32'd5,        32'd0,        32'd5,        SLAT};
    vecs[8]  = '{ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SLAT};
    vecs[9]  = '{ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, SLAT};
    vecs[10] = '{ALU_DIVU,   32'd100,      32'd7,        32'd14,       33};
    vecs[11] = '{ALU_REMU,   32'd100,      32'd7,        32'd2,        33};
    vecs[12] = '{ALU_DIV,    32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 33};
    vecs[13] = '{ALU_REM,    32'd20,       32'hFFFFFFFD, 32'd2,        33};
    vecs[14] = '{ALU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, SLAT};
    vecs[15] = '{ALU_REM,    32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, SLAT};

    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_result", result, 0);
    #5 rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      #1;
      check($sformatf("v%0d_start_busy", i), busy, 1);
      wait_done(lat, bc, res);
      check($sformatf("v%0d_result", i), res, vecs[i].res_exp);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_busy_cycles", i), 32'(bc), 32'(vecs[i].lat));
      check($sformatf("v%0d_fin_busy", i), busy, 0);
    end

    // Non-M op: never stalls, never completes.
    @(posedge clk); #1;
    saved = result;
    launch(ALU_ADD, 32'd1, 32'd2);
    #1;
    check("add_busy", busy, 0);
    dn = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) dn++;
    end
    check("add_no_done", 32'(dn), 0);
    check("add_result_held", result, saved);

    // Kill after 10 iterations, then a new DIV right away.
    @(posedge clk); #1;
    saved = result;
    launch(ALU_DIV, 32'd1000, 32'd3);
    @(posedge clk); #1;
    start = 1'b0;
    dn = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    check("kill_busy", busy, 0);
    check("kill_done", done, 0);
    check("kill_no_done", 32'(dn), 0);
    check("kill_result_held", result, saved);
    launch(ALU_DIV, 32'd1000, 32'd3);
    #1;
    check("kill_restart_busy", busy, 1);
    wait_done(lat, bc, res);
    check("kill_restart_result", res, 32'd333);
    check("kill_restart_latency", 32'(lat), 32'd33);

    // kill with start in IDLE drops the request.
    @(posedge clk); #1;
    launch(ALU_DIV, 32'd9, 32'd3);
    kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    kill  = 1'b0;
    check("killstart_busy", busy, 0);
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("killstart_no_done", 32'(dn), 0);

    // kill in the FIN cycle does not cancel done.
    @(posedge clk); #1;
    launch(ALU_MUL, 32'd6, 32'd7);
    wait_done(lat, bc, res);
    kill = 1'b1;
    #1;
    check("killfin_done", done, 1);
    check("killfin_result", result, 32'd42);
    @(posedge clk); #1;
    kill = 1'b0;
    check("killfin_after_done", done, 0);

    // Back-to-back: DIVU issued in the FIN cycle of a MUL.
    @(posedge clk); #1;
    launch(ALU_MUL, 32'd3, 32'd5);
    wait_done(lat, bc, res);
    check("b2b_first_result", res, 32'd15);
    launch(ALU_DIVU, 32'd100, 32'd7);
    wait_done(lat, bc, res);
    check("b2b_second_result", res, 32'd14);
    check("b2b_second_latency", 32'(lat), 32'd33);

    // Asynchronous reset at iteration 20.
    @(posedge clk); #1;
    launch(ALU_DIV, 32'd50, 32'd5);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20; k++) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_after_done", done, 0);
    check("rst_after_busy", busy, 0);
    launch(ALU_DIV, 32'd50, 32'd5);
    wait_done(lat, bc, res);
    check("rst_recover_result", res, 32'd10);
    check("rst_recover_latency", 32'(lat), 32'd33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
